// File: rtl/base_hps_sw_pkg.sv
// Shared constants for the slide-switch controller: register word addresses
// and the power-on debounce period.
package base_hps_sw_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_MASK   = 2'd1;
    localparam logic [1:0] ADDR_PERIOD = 2'd2;
    localparam logic [1:0] ADDR_EDGE   = 2'd3;

    // 1 ms at 50 MHz
    localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;

endpackage

// File: rtl/base_hps_sw_ctrl_if.sv
// Avalon-MM register bus between the HPS bridge (master) and the switch
// controller (slave).
interface base_hps_sw_ctrl_if;

    logic [1:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, read, write, writedata, input readdata);
    modport slave  (input address, read, write, writedata, output readdata);

endinterface

// File: rtl/base_hps_sw_ctrl_sw_debounce.sv
// One switch bit: 2-flop synchroniser followed by a counter that only accepts
// a new level after it has persisted for period+1 consecutive cycles.
module sw_debounce #(
    parameter int CNT_W = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             raw,
    input  logic [CNT_W-1:0] period,
    output logic             stable,
    output logic             change_pulse
);

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    // The >= compare also covers a period lowered below the running count.
    always_comb begin
        s1_d         = raw;
        s2_d         = s1_q;
        stable_d     = stable_q;
        cnt_d        = cnt_q;
        change_pulse = 1'b0;
        if (s2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q >= period) begin
            stable_d     = s2_q;
            cnt_d        = '0;
            change_pulse = 1'b1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign stable = stable_q;

endmodule

// File: rtl/base_hps_sw_ctrl.sv
// Switch controller: per-bit debouncers, sticky edge register with W1C,
// interrupt mask, programmable debounce period and registered readback.
module base_hps_sw_ctrl
    import base_hps_sw_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int CNT_W           = 20,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic               clk,
    input  logic               reset,
    base_hps_sw_ctrl_if.slave  bus,
    input  logic [WIDTH-1:0]   in_port,
    output logic               irq
);

    localparam logic [CNT_W-1:0] PERIOD_RST = CNT_W'(DEBOUNCE_CYCLES);

    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] change;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] edge_q, edge_d;
    logic [WIDTH-1:0] edge_clr;
    logic [CNT_W-1:0] period_q, period_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             irq_q, irq_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_db
        sw_debounce #(.CNT_W(CNT_W)) u_db (
            .clk          (clk),
            .reset        (reset),
            .raw          (in_port[i]),
            .period       (period_q),
            .stable       (stable[i]),
            .change_pulse (change[i])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_q     <= '0;
            edge_q     <= '0;
            period_q   <= PERIOD_RST;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            mask_q     <= mask_d;
            edge_q     <= edge_d;
            period_q   <= period_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    always_comb begin
        mask_d   = mask_q;
        period_d = period_q;
        edge_clr = '0;
        if (bus.write) begin
            case (bus.address)
                ADDR_MASK:   mask_d   = bus.writedata[WIDTH-1:0];
                ADDR_PERIOD: period_d = bus.writedata[CNT_W-1:0];
                ADDR_EDGE:   edge_clr = bus.writedata[WIDTH-1:0];
                default:     ;
            endcase
        end
        // A new edge in the same cycle as its W1C keeps the bit set.
        edge_d = (edge_q & ~edge_clr) | change;
        irq_d  = |(edge_q & mask_q);
    end

    // Readback reflects pre-write state, so a same-cycle write is not visible.
    always_comb begin
        readdata_d = '0;
        case (bus.address)
            ADDR_DATA:   readdata_d[WIDTH-1:0] = stable;
            ADDR_MASK:   readdata_d[WIDTH-1:0] = mask_q;
            ADDR_PERIOD: readdata_d[CNT_W-1:0] = period_q;
            ADDR_EDGE:   readdata_d[WIDTH-1:0] = edge_q;
            default:     ;
        endcase
    end

    logic unused_bus_bits;
    assign unused_bus_bits = ^{bus.read, bus.writedata};

    assign bus.readdata = readdata_q;
    assign irq          = irq_q;

endmodule

// File: tb/tb_base_hps_sw_ctrl.sv
// Scoreboard bench for base_hps_sw_ctrl: directed switch waveforms and bus
// accesses; expected register/irq values are queued at issue time.
module tb_base_hps_sw_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] in_port = 4'b0000;
    logic       irq;

    base_hps_sw_ctrl_if bus ();

    base_hps_sw_ctrl dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .in_port (in_port),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          do_rd;
        logic [1:0]  addr;
        logic [31:0] exp_d;
        bit          do_irq;
        logic        exp_irq;
        string       nm;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    logic probe = 1'b0;
    logic fire = 1'b0;
    logic irq_smp = 1'b0;

    // irq is sampled before the edge so it matches the state readdata captures.
    always @(posedge clk) begin
        fire    <= probe;
        irq_smp <= irq;
    end

    always @(negedge clk) begin
        exp_t e;
        if (fire) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL monitor: output presented with empty queue");
            end else begin
                e = sbq.pop_front();
                if (e.do_rd) begin
                    checks++;
                    if (bus.readdata !== e.exp_d) begin
                        errors++;
                        $display("FAIL %s: readdata got 0x%0h want 0x%0h", e.nm, bus.readdata, e.exp_d);
                    end
                end
                if (e.do_irq) begin
                    checks++;
                    if (irq_smp !== e.exp_irq) begin
                        errors++;
                        $display("FAIL %s irq: got %b want %b", e.nm, irq_smp, e.exp_irq);
                    end
                end
            end
        end
    end

    // Called on a falling edge; the expectation describes state at this edge.
    task automatic issue(input bit rd, input logic [1:0] a, input logic [31:0] ed,
                         input bit ci, input logic ei, input string nm);
        exp_t e;
        e.do_rd = rd; e.addr = a; e.exp_d = ed; e.do_irq = ci; e.exp_irq = ei; e.nm = nm;
        sbq.push_back(e);
        bus.read    = rd;
        bus.address = a;
        probe       = 1'b1;
        @(negedge clk);
        bus.read = 1'b0;
        probe    = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.write     = 1'b1;
        bus.address   = a;
        bus.writedata = d;
        @(negedge clk);
        bus.write = 1'b0;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    initial begin
        bus.address   = 2'd0;
        bus.read      = 1'b0;
        bus.write     = 1'b0;
        bus.writedata = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state
        issue(1, 2'd0, 32'd0,     1, 1'b0, "rst_data");
        issue(1, 2'd1, 32'd0,     0, 1'b0, "rst_mask");
        issue(1, 2'd2, 32'd50000, 0, 1'b0, "rst_period");
        issue(1, 2'd3, 32'd0,     1, 1'b0, "rst_edge");

        // Clean rise on bit0, period 10
        wr(2'd2, 32'd10);
        wr(2'd1, 32'd1);
        in_port = 4'b0001;
        repeat (12) @(negedge clk);
        issue(1, 2'd0, 32'd0, 0, 1'b0, "b0_before");
        issue(1, 2'd0, 32'd1, 1, 1'b0, "b0_stable");
        issue(1, 2'd3, 32'd1, 1, 1'b1, "b0_edge_irq");
        wr(2'd3, 32'd1);
        issue(1, 2'd3, 32'd0, 1, 1'b1, "b0_w1c");
        issue(1, 2'd1, 32'd1, 1, 1'b0, "b0_irq_drop");

        // Bounce on bit1 (masked)
        in_port = 4'b0011;
        repeat (5) @(negedge clk);
        in_port = 4'b0001;
        repeat (3) @(negedge clk);
        in_port = 4'b0011;
        issue(1, 2'd0, 32'd1, 0, 1'b0, "b1_bounce");
        repeat (11) @(negedge clk);
        issue(1, 2'd0, 32'd1, 0, 1'b0, "b1_before");
        issue(1, 2'd0, 32'd3, 1, 1'b0, "b1_stable");
        issue(1, 2'd3, 32'd2, 1, 1'b0, "b1_edge");
        issue(1, 2'd1, 32'd1, 1, 1'b0, "b1_masked");

        // Fall on bit0 gives EDGE=0011, then W1C bit0
        in_port = 4'b0010;
        repeat (13) @(negedge clk);
        issue(1, 2'd3, 32'd3, 1, 1'b0, "b0f_edge");
        issue(1, 2'd0, 32'd2, 1, 1'b1, "b0f_irq");
        wr(2'd3, 32'd1);
        issue(1, 2'd3, 32'd2, 1, 1'b1, "w1c_edge");
        issue(1, 2'd3, 32'd2, 1, 1'b0, "w1c_irq_drop");

        // Set wins over clear on bit2
        in_port = 4'b0110;
        repeat (12) @(negedge clk);
        wr(2'd3, 32'd4);
        issue(1, 2'd3, 32'd6, 0, 1'b0, "setwins_edge");
        issue(1, 2'd0, 32'd6, 0, 1'b0, "setwins_data");
        wr(2'd3, 32'd4);
        issue(1, 2'd3, 32'd2, 0, 1'b0, "b2_clear");

        // Period 0: single-cycle glitch on bit3 passes through
        wr(2'd2, 32'd0);
        in_port = 4'b1110;
        @(negedge clk);
        in_port = 4'b0110;
        @(negedge clk);
        issue(1, 2'd0, 32'h6, 0, 1'b0, "p0_pre");
        issue(1, 2'd0, 32'hE, 0, 1'b0, "p0_pulse");
        issue(1, 2'd0, 32'h6, 0, 1'b0, "p0_post");
        issue(1, 2'd3, 32'hA, 1, 1'b0, "p0_edge");

        // Reset in the middle of a long count
        wr(2'd2, 32'd1000);
        wr(2'd1, 32'hF);
        issue(1, 2'd1, 32'hF,    1, 1'b0, "mask_all");
        issue(1, 2'd2, 32'd1000, 1, 1'b1, "mask_all_irq");
        in_port = 4'b0111;
        repeat (20) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async_irq", {31'd0, irq}, 32'd0);
        chk("async_readdata", bus.readdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        issue(1, 2'd0, 32'd0,     1, 1'b0, "rr_data");
        issue(1, 2'd1, 32'd0,     0, 1'b0, "rr_mask");
        issue(1, 2'd2, 32'd50000, 0, 1'b0, "rr_period");
        issue(1, 2'd3, 32'd0,     1, 1'b0, "rr_edge");

        repeat (3) @(negedge clk);
        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d entries left want 0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
